// File: rtl/prog_loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : definitions (package)
//  Description : Shared types and constants for the program loader.
//  Revision    : 1.0 - initial release
// ============================================================================
package definitions;

    // Loader phases: fill memory, let the core run, freeze for readout.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } ld_state_t;

    // Width of the run-cycle counter.
    localparam int kRunCntW = 16;

endpackage : definitions
`default_nettype wire

// File: rtl/prog_loader_if.sv
`default_nettype none
// ============================================================================
//  Module      : prog_loader_if
//  Description : Host stream, instruction-memory write port and core control
//                signals of the program loader, bundled as one interface.
//  Revision    : 1.0 - initial release
// ============================================================================
interface prog_loader_if #(
    parameter int AW = 8,
    parameter int IW = 9
);
    import definitions::*;

    logic                start;
    logic                s_valid;
    logic [IW-1:0]       s_data;
    logic                s_last;
    logic                s_ready;
    logic                im_we;
    logic [AW-1:0]       im_addr;
    logic [IW-1:0]       im_din;
    logic                core_reset;
    logic                core_done;
    logic                loaded;
    logic                err;
    logic [kRunCntW-1:0] run_cycles;

    // Host / system side.
    modport master (
        output start, s_valid, s_data, s_last, core_done,
        input  s_ready, im_we, im_addr, im_din, core_reset, loaded, err, run_cycles
    );

    // Loader side.
    modport slave (
        input  start, s_valid, s_data, s_last, core_done,
        output s_ready, im_we, im_addr, im_din, core_reset, loaded, err, run_cycles
    );

endinterface : prog_loader_if
`default_nettype wire

// File: rtl/prog_loader_sat_counter.sv
`default_nettype none
// ============================================================================
//  Module      : sat_counter
//  Description : Up-counter with synchronous clear and enable that sticks at
//                its all-ones value instead of wrapping.
//  Revision    : 1.0 - initial release
// ============================================================================
module sat_counter
    import definitions::*;
#(
    parameter int W = kRunCntW
) (
    input  wire logic         clk,
    input  wire logic         reset,
    input  wire logic         clear,
    input  wire logic         enable,
    output logic [W-1:0]      count
);

    // Count enabled cycles; clear wins over enable; hold at the ceiling.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != {W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule : sat_counter
`default_nettype wire

// File: rtl/prog_loader.sv
`default_nettype none
// ============================================================================
//  Module      : prog_loader
//  Description : Fills instruction memory from a host word stream while the
//                core is held in reset, releases the core to run, and freezes
//                it again when the core signals done.
//                Build option LOADER_CHECKSUM_EN: the s_last word is an XOR
//                checksum of the program rather than an instruction.
//  Revision    : 1.0 - initial release
// ============================================================================
module prog_loader
    import definitions::*;
#(
    parameter int AW    = 8,
    parameter int IW    = 9,
    parameter int DEPTH = 256
) (
    input  wire logic     clk,
    input  wire logic     reset,
    prog_loader_if.slave  bus
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    ld_state_t     state_q;
    ld_state_t     state_d;
    logic [AW-1:0] wptr;
    logic          ready_q;
    logic          we_q;
    logic [AW-1:0] addr_q;
    logic [IW-1:0] din_q;
    logic          core_reset_q;
    logic          loaded_q;
    logic          err_q;

    logic          handshake;
    logic          write_word;
    logic          last_written;
    logic          sum_ok;
    logic          clear;
    logic          go_run;
    logic          set_err;

    assign handshake = bus.s_valid & ready_q;

`ifdef LOADER_CHECKSUM_EN
    logic [IW-1:0] csum;

    // The last word carries the checksum and never reaches memory.
    assign last_written = 1'b0;
    assign sum_ok       = (csum == bus.s_data);

    // Running XOR of every word committed to memory in this load.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            csum <= '0;
        end else if (clear) begin
            csum <= '0;
        end else if (write_word) begin
            csum <= csum ^ bus.s_data;
        end
    end
`else
    assign last_written = 1'b1;
    assign sum_ok       = 1'b1;
`endif

    assign write_word = handshake & (~bus.s_last | last_written);

    // Next-state decode and the one-cycle control strobes.
    always_comb begin
        state_d = state_q;
        clear   = 1'b0;
        go_run  = 1'b0;
        set_err = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_d = LOAD;
                    clear   = 1'b1;
                end
            end
            LOAD: begin
                if (handshake) begin
                    if (bus.s_last) begin
                        if (sum_ok) begin
                            state_d = RUN;
                            go_run  = 1'b1;
                        end else begin
                            state_d = DONE;
                            set_err = 1'b1;
                        end
                    end else if (wptr == LAST_ADDR) begin
                        // Memory full without an end marker: truncated program.
                        state_d = DONE;
                        set_err = 1'b1;
                    end
                end
            end
            RUN: begin
                if (bus.core_done) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, write pointer and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            wptr         <= '0;
            ready_q      <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            din_q        <= '0;
            core_reset_q <= 1'b1;
            loaded_q     <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q <= state_d;
            ready_q <= (state_d == LOAD);
            we_q    <= write_word;
            if (write_word) begin
                addr_q <= wptr;
                din_q  <= bus.s_data;
            end
            if (clear) begin
                wptr <= '0;
            end else if (write_word) begin
                wptr <= wptr + 1'b1;
            end
            // Released only once RUN has lasted a full cycle, so the last
            // memory write lands before the first fetch; re-asserted as soon
            // as done is seen.
            core_reset_q <= !((state_q == RUN) && (state_d == RUN));
            if (clear) begin
                loaded_q <= 1'b0;
            end else if (go_run) begin
                loaded_q <= 1'b1;
            end
            if (clear) begin
                err_q <= 1'b0;
            end else if (set_err) begin
                err_q <= 1'b1;
            end
        end
    end

    sat_counter #(
        .W (kRunCntW)
    ) u_run_cnt (
        .clk    (clk),
        .reset  (reset),
        .clear  (clear),
        .enable (state_q == RUN),
        .count  (bus.run_cycles)
    );

    assign bus.s_ready    = ready_q;
    assign bus.im_we      = we_q;
    assign bus.im_addr    = addr_q;
    assign bus.im_din     = din_q;
    assign bus.core_reset = core_reset_q;
    assign bus.loaded     = loaded_q;
    assign bus.err        = err_q;

endmodule : prog_loader
`default_nettype wire
